cgra_run_ctrl: RTL

CGRA_RUN_CTRL -- requirements
Module: cgra_run_ctrl

---
 rtl/cgra_run_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cgra_run_ctrl.sv
// Sequences a multi-block CGRA run via a four-phase Start/Done handshake with per-phase timeout and abort.
// All outputs registered (one cycle after the deciding edge); Done is the only backpressure, and DRAIN waits on it unbounded.
module cgra_run_ctrl #(
    parameter int CNT_WIDTH = 16,
    parameter int TMO_WIDTH = 24
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Run_Req,
    input  logic [CNT_WIDTH-1:0] Run_Num_Blocks,
    input  logic [TMO_WIDTH-1:0] Run_Timeout,
    input  logic                 Abort,
    output logic                 Computation_Start,
    input  logic                 Computation_Done,
    output logic [CNT_WIDTH-1:0] Block_Idx,
    output logic                 Run_Busy,
    output logic                 Run_Done,
    output logic                 Run_Error,
    output logic [TMO_WIDTH-1:0] Cycle_Count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        RELEASE = 3'd2,
        DRAIN   = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] num_q;
    logic [TMO_WIDTH-1:0] tmo_q;
    logic [TMO_WIDTH-1:0] phase_q, phase_nxt;
    logic                 accept, zero_req, err_set, idx_inc, tmo_hit;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_req  = 1'b0;
        err_set   = 1'b0;
        idx_inc   = 1'b0;
        tmo_hit   = (tmo_q != '0) && (phase_q == tmo_q - TMO_ONE);

        case (state)
            IDLE: begin
                if (Run_Req) begin
                    if (Run_Num_Blocks != '0) begin
                        accept    = 1'b1;
                        state_nxt = ASSERT;
                    end else begin
                        zero_req = 1'b1;
                    end
                end
            end
            // Abort and timeout win over a Done edge arriving in the same cycle.
            ASSERT: begin
                if (Abort || tmo_hit) begin
                    err_set   = 1'b1;
                    state_nxt = DRAIN;
                end else if (Computation_Done) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (Abort || tmo_hit) begin
                    err_set   = 1'b1;
                    state_nxt = DRAIN;
                end else if (!Computation_Done) begin
                    if (Block_Idx + CNT_ONE == num_q) begin
                        state_nxt = FINISH;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = ASSERT;
                    end
                end
            end
            DRAIN: begin
                if (!Computation_Done) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Phase timer restarts on every entry to a handshake phase, including RELEASE->ASSERT.
        if (state_nxt != state) begin
            phase_nxt = '0;
        end else if (state == ASSERT || state == RELEASE) begin
            phase_nxt = phase_q + TMO_ONE;
        end else begin
            phase_nxt = phase_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state             <= IDLE;
            num_q             <= '0;
            tmo_q             <= '0;
            phase_q           <= '0;
            Computation_Start <= 1'b0;
            Block_Idx         <= '0;
            Run_Busy          <= 1'b0;
            Run_Done          <= 1'b0;
            Run_Error         <= 1'b0;
            Cycle_Count       <= '0;
        end else begin
            state             <= state_nxt;
            phase_q           <= phase_nxt;
            Computation_Start <= (state_nxt == ASSERT);
            Run_Busy          <= (state_nxt != IDLE);
            Run_Done          <= (state_nxt == FINISH) || zero_req;

            if (accept) begin
                num_q       <= Run_Num_Blocks;
                tmo_q       <= Run_Timeout;
                Block_Idx   <= '0;
                Run_Error   <= 1'b0;
                Cycle_Count <= '0;
            end else begin
                if (idx_inc) Block_Idx <= Block_Idx + CNT_ONE;
                if (err_set) Run_Error <= 1'b1;
                // An empty run reports zero busy cycles.
                if (zero_req) begin
                    Cycle_Count <= '0;
                end else if (Run_Busy && Cycle_Count != '1) begin
                    Cycle_Count <= Cycle_Count + TMO_ONE;
                end
            end
        end
    end

endmodule
